// File: rtl/bitwise_logic_unit.sv
// ----------------------------------------------------------------------------
// bitwise_logic_unit
//
// Registered WIDTH-bit logic/arithmetic leaf. On each rising clk edge with
// in_valid=1 it captures AND, OR and XOR of the operands. When the adder is
// compiled in, it also captures the ripple-carry sum and its carry. It also
// captures one selected result onto mux_out. Every output comes straight from
// a flop, so there is no combinational path from any input to any output.
//
// Optional feature macro: BITWISE_LOGIC_UNIT_ADDER_EN
//   defined   - the adder is built. sum_out/carry_out are live and sel=3
//               selects the sum.
//   undefined - there is no adder. sum_out/carry_out are tied to 0 and sel=3
//               yields zeros.
//
// Parameters:
//   WIDTH      operand and result width in bits (min 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every output
//   in_valid   operands valid; results are captured on this edge
//   a, b       operands
//   carry_in   adder carry input
//   sel        mux_out select:
//                0 AND, 1 OR, 2 XOR, 3 sum, 4 NAND, 5 NOR, 6 XNOR, 7 a,
//                8-15 zero
//   and_out    registered a & b
//   or_out     registered a | b
//   xor_out    registered a ^ b
//   sum_out    registered (a + b + carry_in) mod 2^WIDTH
//   carry_out  registered carry out of the sum MSB
//   mux_out    registered selected result
//   out_valid  registered copy of in_valid
// ----------------------------------------------------------------------------
module bitwise_logic_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] or_out,
    output logic [WIDTH-1:0] xor_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic [WIDTH-1:0] mux_out,
    output logic             out_valid
);

    // Result selection. The sum slot carries zeros when the adder is absent,
    // because w_sum is tied to zero in that build.
    function automatic logic [WIDTH-1:0] f_select(
        input logic [3:0]       s,
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_and,
        input logic [WIDTH-1:0] op_or,
        input logic [WIDTH-1:0] op_xor,
        input logic [WIDTH-1:0] op_sum
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (s)
            4'd0:    r = op_and;
            4'd1:    r = op_or;
            4'd2:    r = op_xor;
            4'd3:    r = op_sum;
            4'd4:    r = ~op_and;
            4'd5:    r = ~op_or;
            4'd6:    r = ~op_xor;
            4'd7:    r = op_a;
            default: r = '0;
        endcase
        return r;
    endfunction

    // ---- stage p0: combinational results from the operand inputs ----
    logic [WIDTH-1:0] w_and_p0;
    logic [WIDTH-1:0] w_or_p0;
    logic [WIDTH-1:0] w_xor_p0;
    logic [WIDTH-1:0] w_sum_p0;
    logic [WIDTH-1:0] w_mux_p0;

    assign w_and_p0 = a & b;
    assign w_or_p0  = a | b;
    assign w_xor_p0 = a ^ b;

`ifdef BITWISE_LOGIC_UNIT_ADDER_EN
    logic [WIDTH:0] w_sum_full_p0;

    // The sum is one bit wider than the operands so that the top bit is the
    // carry out of the MSB.
    assign w_sum_full_p0 = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
    assign w_sum_p0      = w_sum_full_p0[WIDTH-1:0];
`else
    // carry_in has no consumer in this build.
    logic w_unused_carry_in;

    assign w_unused_carry_in = carry_in;
    assign w_sum_p0          = '0;
`endif

    assign w_mux_p0 = f_select(sel, a, w_and_p0, w_or_p0, w_xor_p0, w_sum_p0);

    // ---- stage p1: output registers, loaded only when in_valid=1 ----
    logic [WIDTH-1:0] r_and_p1;
    logic [WIDTH-1:0] r_or_p1;
    logic [WIDTH-1:0] r_xor_p1;
    logic [WIDTH-1:0] r_mux_p1;
    logic             r_vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_and_p1 <= '0;
            r_or_p1  <= '0;
            r_xor_p1 <= '0;
            r_mux_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_and_p1 <= w_and_p0;
                r_or_p1  <= w_or_p0;
                r_xor_p1 <= w_xor_p0;
                r_mux_p1 <= w_mux_p0;
            end
        end
    end

`ifdef BITWISE_LOGIC_UNIT_ADDER_EN
    logic [WIDTH-1:0] r_sum_p1;
    logic             r_carry_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_p1   <= '0;
            r_carry_p1 <= 1'b0;
        end else if (in_valid) begin
            r_sum_p1   <= w_sum_p0;
            r_carry_p1 <= w_sum_full_p0[WIDTH];
        end
    end

    assign sum_out   = r_sum_p1;
    assign carry_out = r_carry_p1;
`else
    assign sum_out   = '0;
    assign carry_out = 1'b0;
`endif

    assign and_out   = r_and_p1;
    assign or_out    = r_or_p1;
    assign xor_out   = r_xor_p1;
    assign mux_out   = r_mux_p1;
    assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
module tb_bitwise_logic_unit;

    localparam int W = 4;
`ifdef BITWISE_LOGIC_UNIT_ADDER_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] and_v;
        logic [W-1:0] or_v;
        logic [W-1:0] xor_v;
        logic [W-1:0] sum_v;
        logic         cout_v;
        logic [W-1:0] mux_v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic         carry_in;
    logic [3:0]   sel;
    logic [W-1:0] and_out, or_out, xor_out, sum_out, mux_out;
    logic         carry_out, out_valid;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];
    exp_t last_exp = '0;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sel       (sel),
        .and_out   (and_out),
        .or_out    (or_out),
        .xor_out   (xor_out),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .mux_out   (mux_out),
        .out_valid (out_valid)
    );

    // Reference: the results are computed with integer arithmetic, and the
    // selection comes from a table of all sixteen candidate outputs.
    function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                   input logic vc, input logic [3:0] vs);
        exp_t         e;
        int unsigned  total;
        logic [W-1:0] table_r [16];
        total    = int'(va) + int'(vb) + int'(vc);
        e.and_v  = va & vb;
        e.or_v   = va | vb;
        e.xor_v  = va ^ vb;
        e.sum_v  = ADD_EN ? W'(total % (1 << W)) : '0;
        e.cout_v = ADD_EN ? (total >= (1 << W)) : 1'b0;
        for (int i = 0; i < 16; i++) table_r[i] = '0;
        table_r[0] = e.and_v;
        table_r[1] = e.or_v;
        table_r[2] = e.xor_v;
        table_r[3] = e.sum_v;
        table_r[4] = ~e.and_v;
        table_r[5] = ~e.or_v;
        table_r[6] = ~e.xor_v;
        table_r[7] = va;
        e.mux_v    = table_r[vs];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e, input logic vld);
        check({tag, ".and"},   32'(and_out),   32'(e.and_v));
        check({tag, ".or"},    32'(or_out),    32'(e.or_v));
        check({tag, ".xor"},   32'(xor_out),   32'(e.xor_v));
        check({tag, ".sum"},   32'(sum_out),   32'(e.sum_v));
        check({tag, ".cout"},  32'(carry_out), 32'(e.cout_v));
        check({tag, ".mux"},   32'(mux_out),   32'(e.mux_v));
        check({tag, ".valid"}, 32'(out_valid), 32'(vld));
    endtask

    // Drive one cycle of stimulus at the falling edge. When the cycle is
    // valid, the expected response is queued for the monitor.
    task automatic drive(input logic v, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input logic [3:0] vs);
        @(negedge clk);
        in_valid = v;
        a        = va;
        b        = vb;
        carry_in = vc;
        sel      = vs;
        if (v) sb_q.push_back(model(va, vb, vc, vs));
    endtask

    // Monitor: samples 1 time unit after each rising edge. A valid output pops
    // and compares against the queue. An idle cycle must hold the last
    // results.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                last_exp = '0;
            end else if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    last_exp = sb_q.pop_front();
                    check_outputs("valid", last_exp, 1'b1);
                end
            end else begin
                check_outputs("hold", last_exp, 1'b0);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        sel      = '0;
        #3;
        check_outputs("reset", '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, including the wrap and carry boundaries.
        drive(1, 4'b0000, 4'b0000, 1, 4'd0);
        drive(1, 4'b0001, 4'b1110, 0, 4'd1);
        drive(1, 4'b1110, 4'b0001, 1, 4'd3);
        drive(1, 4'b1111, 4'b1111, 1, 4'd2);
        drive(1, 4'b1111, 4'b1111, 0, 4'd2);
        drive(1, 4'b1110, 4'b0001, 0, 4'd6);
        for (int s = 0; s < 16; s++) drive(1, 4'b1010, 4'b0110, s[0], 4'(s));

        // Hold while in_valid is low, even though the operands change.
        drive(1, 4'b0101, 4'b0011, 1, 4'd7);
        drive(0, 4'b1111, 4'b0000, 1, 4'd4);
        drive(0, 4'b0110, 4'b1001, 0, 4'd3);

        // Asynchronous reset asserted between edges.
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_outputs("async_reset", '0, 1'b0);
        @(posedge clk);
        #1 check_outputs("reset_held", '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic with random idle cycles.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                  1'($urandom), 4'($urandom_range(0, 15)));
        end
        drive(0, '0, '0, 0, 4'd0);

        // Drain: the queue must empty within a bounded number of cycles.
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

- Registered W-bit bitwise/arithmetic unit.
- Computes AND, OR and XOR of two operands in parallel, plus an optional ripple-carry sum.
- Selects one result onto a muxed output.
- Sits as a small leaf datapath element behind the operand registers; all results appear one clock after a valid input.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (min 1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle; results captured on this edge
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  adder carry input
- sel  input  4  result select for mux_out
- and_out  output  WIDTH  registered a & b
- or_out  output  WIDTH  registered a | b
- xor_out  output  WIDTH  registered a ^ b
- sum_out  output  WIDTH  registered (a + b + carry_in) mod 2^WIDTH
- carry_out  output  1  registered carry out of the MSB of the sum
- mux_out  output  WIDTH  registered selected result
- out_valid  output  1  registered copy of in_valid

## Operation
- Every rising clk edge with in_valid=1 captures all results into registers:
  - and_out, or_out, xor_out: bitwise per bit index.
  - {carry_out, sum_out} = a + b + carry_in, WIDTH+1-bit unsigned add. No overflow flag; wrap-around is modulo 2^WIDTH, carry exposes the overflow.
  - mux_out by sel:
    - 0 → AND
    - 1 → OR
    - 2 → XOR
    - 3 → sum
    - 4 → ~(a & b)
    - 5 → ~(a | b)
    - 6 → ~(a ^ b)
    - 7 → a
    - 8–15 → all zeros
- in_valid=0: all result registers hold their previous values; out_valid goes 0 on that edge.
- No internal state beyond the output registers; no FSM.
- Changes on a, b, carry_in or sel while in_valid=0 have no effect on outputs.

## Timing
- Latency: exactly 1 cycle from the capturing edge (in_valid=1) to outputs and out_valid=1.
- Throughput: one operation per cycle; back-to-back valid inputs each produce results on consecutive cycles.
- Reset (rst_n=0, asynchronous, any time including mid-stream):
  - All outputs go 0 immediately, including out_valid, mux_out and carry_out.
  - Outputs hold 0 while rst_n=0.
- Reset release: first capture occurs on the first rising edge with rst_n=1 and in_valid=1. Reset deassertion is synchronised externally.
- All outputs are driven directly from flops; no combinational input-to-output path.

## Configuration
- BITWISE_LOGIC_UNIT_ADDER_EN defined: the adder is compiled in; sum_out/carry_out behave as above; sel=3 selects the sum.
- Macro undefined:
  - Adder logic is absent.
  - sum_out and carry_out are constant 0.
  - sel=3 yields mux_out all zeros.
  - All other selections are unchanged.

## Test plan
Each line: stimulus → required response one cycle later, macro defined, WIDTH=4.
1. a=0, b=0, carry_in=1, sel=0, in_valid=1 → and=0000, or=0000, xor=0000, sum=0001, carry_out=0, mux_out=0000, out_valid=1.
2. a=0001, b=1110, carry_in=0, sel=1 → and=0000, or=1111, xor=1111, sum=1111, carry_out=0, mux_out=1111.
3. a=1110, b=0001, carry_in=1, sel=3 → and=0000, or=1111, xor=1111, sum=0000, carry_out=1, mux_out=0000.
4. a=1111, b=1111, carry_in=1 then carry_in=0, sel=2 → and=1111, or=1111, xor=0000, mux_out=0000; sum=1111 then 1110, carry_out=1 both cycles.
5. Valid op then in_valid=0 with new operands → results hold, out_valid=0. Then assert rst_n=0 between edges → all outputs 0 immediately, before the next clk edge.
6. Macro undefined, a=1110, b=0001, sel=3 → sum_out=0000, carry_out=0, mux_out=0000; sel=6 → mux_out=0000 (XNOR).
